// File: rtl/intrp_seg_gen.sv
// Segment generator for the batch interpolater.
// It takes a stream of waypoints, each a target value and a duration in batches. For every
// batch it emits the first sample x and a signed Q(M.N) per-sample slope. The slope comes
// from a bit-serial restoring divider. The start value is snapped to the target at the end
// of each segment, so slope truncation never accumulates across segments.
module intrp_seg_gen #(
  parameter int unsigned BATCH_SIZE   = 16,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned M            = 16,
  parameter int unsigned N            = 16,
  parameter int unsigned DUR_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic signed [SAMPLE_WIDTH-1:0] wp_value,
  input  logic        [DUR_WIDTH-1:0]    wp_dur,
  input  logic                           wp_valid,
  output logic                           wp_ready,
  output logic signed [SAMPLE_WIDTH-1:0] x,
  output logic signed [M+N-1:0]          slope,
  output logic                           seg_valid,
  input  logic                           seg_ready,
  output logic                           busy
);

  localparam int unsigned QW    = M + N;
  localparam int unsigned LOG2B = $clog2(BATCH_SIZE);
  localparam int unsigned DIVW  = DUR_WIDTH + LOG2B;
  localparam int unsigned RW    = DIVW + 1;
  localparam int unsigned DW    = SAMPLE_WIDTH + 1;
  localparam int unsigned AW    = SAMPLE_WIDTH + N + 1;
  localparam int unsigned CW    = $clog2(QW + 2);

  typedef enum logic [1:0] {StIdle, StWaitWp, StDivide, StEmit} state_e;

  state_e state_q, state_d;

  logic signed [SAMPLE_WIDTH-1:0] p_q, p_d, v_q, v_d;
  logic        [DUR_WIDTH-1:0]    d_q, d_d, ecnt_q, ecnt_d;
  logic        [CW-1:0]           dcnt_q, dcnt_d;
  logic        [QW-1:0]           dq_q, dq_d;
  logic        [RW-1:0]           rem_q, rem_d;
  logic                           neg_q, neg_d;
  logic signed [QW-1:0]           slope_q, slope_d;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic                           seg_valid_q, seg_valid_d;

  logic                 wp_fire, seg_fire, div_done, last_batch, trial_ge;
  logic signed [DW-1:0] diff;
  logic        [DW-1:0] mag;
  logic        [QW-1:0] dividend;
  logic      [DIVW-1:0] divisor;
  logic        [RW-1:0] trial;
  logic signed [AW-1:0] step, acc_start;
  logic        [AW-1:0] acc_rnd;
  logic                 unused_bits;

  assign wp_fire    = wp_valid & wp_ready;
  assign seg_fire   = seg_valid_q & seg_ready;
  // dcnt: 0 = operand setup, 1..QW = quotient bits, QW+1 = sign fix-up and EMIT entry
  assign div_done   = (dcnt_q == CW'(QW + 1));
  assign last_batch = (ecnt_q == d_q - DUR_WIDTH'(1));

  // Divider operands and the per-batch accumulator step
  always_comb begin
    diff      = $signed({v_q[SAMPLE_WIDTH-1], v_q}) - $signed({p_q[SAMPLE_WIDTH-1], p_q});
    mag       = diff[DW-1] ? DW'(-diff) : DW'(diff);
    dividend  = QW'(mag) << N;
    divisor   = DIVW'(d_q) << LOG2B;
    trial     = {rem_q[RW-2:0], dq_q[QW-1]};
    trial_ge  = (trial >= {1'b0, divisor});
    step      = $signed({{(AW - QW){slope_q[QW-1]}}, slope_q}) <<< LOG2B;
    acc_start = $signed({p_q[SAMPLE_WIDTH-1], p_q, {N{1'b0}}});
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (wp_fire) state_d = StWaitWp;
      StWaitWp: if (wp_fire && (wp_dur != '0)) state_d = StDivide;
      StDivide: if (div_done) state_d = StEmit;
      StEmit:   if (seg_fire && last_batch) state_d = StWaitWp;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs; x is the rounded view of the accumulator
  always_comb begin
    wp_ready  = rstn & ((state_q == StIdle) | (state_q == StWaitWp));
    busy      = (state_q == StDivide) | (state_q == StEmit);
    seg_valid = seg_valid_q;
    slope     = slope_q;
    acc_rnd   = acc_q + (AW'(1) << (N - 1));
    x         = acc_rnd[N +: SAMPLE_WIDTH];
  end

  assign unused_bits = ^{acc_rnd[AW-1], acc_rnd[N-1:0], rem_q[RW-1]};

  // Datapath next-state: waypoint capture, divider iterations, batch accumulation
  always_comb begin
    p_d         = p_q;
    v_d         = v_q;
    d_d         = d_q;
    ecnt_d      = ecnt_q;
    dcnt_d      = dcnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    neg_d       = neg_q;
    slope_d     = slope_q;
    acc_d       = acc_q;
    seg_valid_d = seg_valid_q;
    unique case (state_q)
      StIdle: begin
        if (wp_fire) p_d = wp_value;
      end
      StWaitWp: begin
        if (wp_fire) begin
          v_d    = wp_value;
          d_d    = wp_dur;
          dcnt_d = '0;
          // Zero duration is an instantaneous jump
          if (wp_dur == '0) p_d = wp_value;
        end
      end
      StDivide: begin
        dcnt_d = dcnt_q + CW'(1);
        if (dcnt_q == '0) begin
          dq_d  = dividend;
          rem_d = '0;
          neg_d = diff[DW-1];
        end else if (!div_done) begin
          rem_d = trial_ge ? (trial - {1'b0, divisor}) : trial;
          dq_d  = {dq_q[QW-2:0], trial_ge};
        end else begin
          slope_d     = neg_q ? -$signed(dq_q) : $signed(dq_q);
          acc_d       = acc_start;
          ecnt_d      = '0;
          seg_valid_d = 1'b1;
        end
      end
      StEmit: begin
        if (seg_fire) begin
          acc_d  = acc_q + step;
          ecnt_d = ecnt_q + DUR_WIDTH'(1);
          if (last_batch) begin
            p_d         = v_q;
            seg_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      p_q         <= '0;
      v_q         <= '0;
      d_q         <= '0;
      ecnt_q      <= '0;
      dcnt_q      <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
      slope_q     <= '0;
      acc_q       <= '0;
      seg_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      v_q         <= v_d;
      d_q         <= d_d;
      ecnt_q      <= ecnt_d;
      dcnt_q      <= dcnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      neg_q       <= neg_d;
      slope_q     <= slope_d;
      acc_q       <= acc_d;
      seg_valid_q <= seg_valid_d;
    end
  end

endmodule
